// File: rtl/semaforo_defs.sv
// ---------------------------------------------------------------------------
// semaforo_defs
// Shared definitions for the semaforo traffic-light controller and its
// upstream pedestrian-button conditioner.
//   - FSM state encodings for button_conditioner (IDLE/PENDING/LOCKOUT)
//   - default DEBOUNCE / LOCKOUT values
//   - 8-bit count width, also used for the VERDE/AMARELO/VERMELHO durations
// ---------------------------------------------------------------------------
package semaforo_defs;

    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam cnt_t DEF_DEBOUNCE = 8'd4;
    localparam cnt_t DEF_LOCKOUT  = 8'd8;

endpackage

// File: rtl/bt_sync_debounce.sv
// ---------------------------------------------------------------------------
// bt_sync_debounce
// Two-flop synchronizer, counter debounce and rising-edge strobe for a raw,
// bouncy, asynchronous push button.
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_bt_raw      raw button input (asynchronous to i_clk)
//   o_press_pulse one-cycle strobe on each debounced 0->1 transition
// Parameter:
//   DEBOUNCE      consecutive differing cycles needed to accept a level (1..255)
// ---------------------------------------------------------------------------
module bt_sync_debounce
    import semaforo_defs::*;
#(
    parameter cnt_t DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bt_raw,
    output logic o_press_pulse
);

    logic r_s1;
    logic r_s;
    logic r_db;
    cnt_t r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s  <= 1'b0;
        end else begin
            r_s1 <= i_bt_raw;
            r_s  <= r_s1;
        end
    end

    // Any cycle where the synchronized level matches the accepted level
    // restarts the count, so isolated bounces never reach DEBOUNCE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db          <= 1'b0;
            r_cnt         <= '0;
            o_press_pulse <= 1'b0;
        end else begin
            o_press_pulse <= 1'b0;
            if (r_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE - 8'd1) begin
                r_db          <= r_s;
                r_cnt         <= '0;
                o_press_pulse <= r_s;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Turns the raw pedestrian button into one clean request held until the
// semaforo controller acknowledges it, followed by a lockout window.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   bt_raw       raw button (asynchronous, bouncy)
//   ack          acknowledge from the controller (one or more cycles)
//   req          latched request, drives the controller's bt input
//   press_pulse  one-cycle strobe per debounced press, accepted or not
//   busy         high whenever the FSM is not IDLE
//   press_count  (BUTTON_CONDITIONER_COUNT_EN only) saturating count of
//                accepted requests
// Parameters:
//   DEBOUNCE     debounce length in cycles (1..255)
//   LOCKOUT      cycles after ack during which presses are dropped (0..255)
// Optional build macro: BUTTON_CONDITIONER_COUNT_EN
// ---------------------------------------------------------------------------
module button_conditioner
    import semaforo_defs::*;
#(
    parameter cnt_t DEBOUNCE = DEF_DEBOUNCE,
    parameter cnt_t LOCKOUT  = DEF_LOCKOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic bt_raw,
    input  logic ack,
    output logic req,
    output logic press_pulse,
    output logic busy
`ifdef BUTTON_CONDITIONER_COUNT_EN
    ,
    output cnt_t press_count
`endif
);

    logic [1:0] r_state;
    cnt_t       r_lk;
    logic       w_press;

    bt_sync_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sync_debounce (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_bt_raw      (bt_raw),
        .o_press_pulse (w_press)
    );

    always_comb press_pulse = w_press;
    always_comb busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lk    <= '0;
            req     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ack arriving here is stale; a simultaneous press wins
                    if (w_press) begin
                        r_state <= ST_PENDING;
                        req     <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (ack) begin
                        req <= 1'b0;
                        if (LOCKOUT == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOCKOUT;
                            r_lk    <= LOCKOUT - 8'd1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_lk == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_lk <= r_lk - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    req     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUTTON_CONDITIONER_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_count <= '0;
        end else if ((r_state == ST_IDLE) && w_press && (press_count != '1)) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner: three instances cover the default
// configuration (DEBOUNCE=4, LOCKOUT=8), LOCKOUT=0 and DEBOUNCE=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;

    logic bt_a, ack_a, req_a, pp_a, busy_a;   // DEBOUNCE=4, LOCKOUT=8
    logic bt_b, ack_b, req_b, pp_b, busy_b;   // DEBOUNCE=4, LOCKOUT=0
    logic bt_c, ack_c, req_c, pp_c, busy_c;   // DEBOUNCE=1, LOCKOUT=8
`ifdef BUTTON_CONDITIONER_COUNT_EN
    logic [7:0] cnt_a, cnt_b, cnt_c;
`endif

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE(8'd4), .LOCKOUT(8'd8)) dut_a (
        .clk(clk), .rst(rst), .bt_raw(bt_a), .ack(ack_a),
        .req(req_a), .press_pulse(pp_a), .busy(busy_a)
`ifdef BUTTON_CONDITIONER_COUNT_EN
        , .press_count(cnt_a)
`endif
    );

    button_conditioner #(.DEBOUNCE(8'd4), .LOCKOUT(8'd0)) dut_b (
        .clk(clk), .rst(rst), .bt_raw(bt_b), .ack(ack_b),
        .req(req_b), .press_pulse(pp_b), .busy(busy_b)
`ifdef BUTTON_CONDITIONER_COUNT_EN
        , .press_count(cnt_b)
`endif
    );

    button_conditioner #(.DEBOUNCE(8'd1), .LOCKOUT(8'd8)) dut_c (
        .clk(clk), .rst(rst), .bt_raw(bt_c), .ack(ack_c),
        .req(req_c), .press_pulse(pp_c), .busy(busy_c)
`ifdef BUTTON_CONDITIONER_COUNT_EN
        , .press_count(cnt_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, landing 1 unit after the last one
    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef BUTTON_CONDITIONER_COUNT_EN
    // one accepted request on dut_c, optionally with an extra ignored press
    task automatic c_request(input bit extra);
        bt_c = 1'b1;
        step(4);
        if (extra) begin
            bt_c = 1'b0;
            step(4);
            bt_c = 1'b1;
            step(4);
        end
        ack_c = 1'b1;
        step(1);
        ack_c = 1'b0;
        bt_c  = 1'b0;
        step(12);
    endtask
`endif

    logic seen;

    initial begin
        rst  = 1'b0;
        bt_a = 1'b0; ack_a = 1'b0;
        bt_b = 1'b0; ack_b = 1'b0;
        bt_c = 1'b0; ack_c = 1'b0;
        #2;
        check("rst_req",  {31'd0, req_a},  32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_pp",   {31'd0, pp_a},   32'd0);
        step(2);
        rst = 1'b1;
        step(3);

        // clean press, edges counted from the bt_a rise
        bt_a = 1'b1;
        step(5);
        check("clean_pp_e5",  {31'd0, pp_a},  32'd0);
        check("clean_req_e5", {31'd0, req_a}, 32'd0);
        step(1);
        check("clean_pp_e6",  {31'd0, pp_a},  32'd1);
        check("clean_req_e6", {31'd0, req_a}, 32'd0);
        step(1);
        check("clean_pp_e7",   {31'd0, pp_a},   32'd0);
        check("clean_req_e7",  {31'd0, req_a},  32'd1);
        check("clean_busy_e7", {31'd0, busy_a}, 32'd1);
        step(2);
        ack_a = 1'b1;
        step(1);
        ack_a = 1'b0;
        check("ack_req_e10",  {31'd0, req_a},  32'd0);
        check("ack_busy_e10", {31'd0, busy_a}, 32'd1);
        step(7);
        check("lock_busy_e17", {31'd0, busy_a}, 32'd1);
        step(1);
        check("lock_busy_e18", {31'd0, busy_a}, 32'd0);
        step(5);
        check("held_no_req", {31'd0, req_a}, 32'd0);

        // release gives no pulse
        bt_a = 1'b0;
        seen = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            step(1);
            seen = seen | pp_a;
        end
        check("release_no_pp", {31'd0, seen}, 32'd0);

        // bounce rejection
        seen = 1'b0;
        for (int unsigned k = 0; k < 6; k++) begin
            bt_a = (k % 2 == 0);
            step(1);
            seen = seen | pp_a;
        end
        bt_a = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            step(1);
            seen = seen | pp_a | req_a;
        end
        check("bounce_no_pp_req", {31'd0, seen}, 32'd0);
        check("bounce_idle", {31'd0, busy_a}, 32'd0);

        // presses during PENDING and LOCKOUT
        bt_a = 1'b1;
        step(7);
        check("p1_req", {31'd0, req_a}, 32'd1);
        bt_a = 1'b0;
        step(8);
        bt_a = 1'b1;
        step(6);
        check("p2_pp",  {31'd0, pp_a},  32'd1);
        check("p2_req", {31'd0, req_a}, 32'd1);
        step(1);
        check("p2_req_held", {31'd0, req_a}, 32'd1);
        bt_a = 1'b0;
        step(7);
        check("p2_req_still", {31'd0, req_a}, 32'd1);
        ack_a = 1'b1;
        bt_a  = 1'b1;
        step(1);
        ack_a = 1'b0;
        check("p3_ack_req", {31'd0, req_a}, 32'd0);
        step(5);
        check("p3_pp_lock", {31'd0, pp_a}, 32'd1);
        step(1);
        check("p3_dropped", {31'd0, req_a}, 32'd0);
        check("p3_busy", {31'd0, busy_a}, 32'd1);
        step(2);
        check("p3_idle", {31'd0, busy_a}, 32'd0);
        check("p3_no_req", {31'd0, req_a}, 32'd0);
        bt_a = 1'b0;
        step(10);

        // LOCKOUT=0: back to IDLE at ack, press one cycle later accepted
        bt_b = 1'b1;
        step(7);
        check("l0_req", {31'd0, req_b}, 32'd1);
        bt_b = 1'b0;
        step(8);
        bt_b = 1'b1;
        step(4);
        ack_b = 1'b1;
        step(1);
        ack_b = 1'b0;
        check("l0_ack_req",  {31'd0, req_b},  32'd0);
        check("l0_ack_busy", {31'd0, busy_b}, 32'd0);
        step(1);
        check("l0_pp", {31'd0, pp_b}, 32'd1);
        step(1);
        check("l0_new_req", {31'd0, req_b}, 32'd1);
        bt_b = 1'b0;

        // DEBOUNCE=1
        bt_c = 1'b1;
        step(3);
        check("d1_pp_e3",  {31'd0, pp_c},  32'd1);
        check("d1_req_e3", {31'd0, req_c}, 32'd0);
        step(1);
        check("d1_req_e4", {31'd0, req_c}, 32'd1);
        bt_c = 1'b0;
        step(4);

        // asynchronous reset while PENDING, button held through release
        bt_a = 1'b1;
        step(6);
        check("rm_pp", {31'd0, pp_a}, 32'd1);
        step(1);
        check("rm_req", {31'd0, req_a}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("rm_req_async",  {31'd0, req_a},  32'd0);
        check("rm_busy_async", {31'd0, busy_a}, 32'd0);
        check("rm_pp_async",   {31'd0, pp_a},   32'd0);
        step(2);
        rst = 1'b1;
        step(6);
        check("rr_pp_e6",  {31'd0, pp_a},  32'd1);
        check("rr_req_e6", {31'd0, req_a}, 32'd0);
        step(1);
        check("rr_req_e7", {31'd0, req_a}, 32'd1);
        bt_a = 1'b0;

`ifdef BUTTON_CONDITIONER_COUNT_EN
        check("cnt_a_after_rst", {24'd0, cnt_a}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("cnt_rst", {24'd0, cnt_c}, 32'd0);
        step(2);
        rst = 1'b1;
        step(2);
        c_request(1'b1);
        c_request(1'b0);
        c_request(1'b1);
        check("cnt_three", {24'd0, cnt_c}, 32'd3);
        for (int unsigned k = 0; k < 300; k++) c_request(1'b0);
        check("cnt_sat", {24'd0, cnt_c}, 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
